// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci index finder.
// State encoding plus default sizing and F(100) for reuse by benches.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int FIB_WIDTH     = 69;
  localparam int FIB_MAX_INDEX = 100;

  localparam logic [FIB_WIDTH-1:0] F_MAX =
    69'd354224848179261915075;

endpackage

// File: rtl/fib_step.sv
// Registered Fibonacci pair (a = F(k), b = F(k-1)) with a+b adder.
// ovf records a carry out of the adder so a wrapped sum never matches.
module fib_step #(
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] a,
  output logic             ovf
);

  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      a   <= WIDTH'(1);
      b   <= '0;
      ovf <= 1'b0;
    end else if (advance) begin
      a   <= sum[WIDTH-1:0];
      b   <= a;
      ovf <= sum[WIDTH];
    end
  end

endmodule

// File: rtl/fib_index_finder.sv
// Decides whether a candidate is a Fibonacci number and finds its index,
// regenerating F(1..MAX_INDEX) one compare+add step per clock.
module fib_index_finder
  import fib_pkg::*;
#(
  parameter  int WIDTH     = FIB_WIDTH,
  parameter  int MAX_INDEX = FIB_MAX_INDEX,
  localparam int IDX_W     = $clog2(MAX_INDEX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] fib_index
);

  state_t           state, state_d;
  logic [WIDTH-1:0] target, target_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [IDX_W-1:0] fib_index_d;
  logic             is_fib_d;
  logic             done_d;
  logic             load;
  logic             advance;

  logic [WIDTH-1:0] a;
  logic             ovf;
  logic             hit;
  logic             over;
  logic             at_max;

  fib_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .advance(advance),
    .a      (a),
    .ovf    (ovf)
  );

  assign hit    = !ovf && (a == target);
  assign over   = ovf || (a > target);
  assign at_max = (idx == IDX_W'(MAX_INDEX));
  assign busy   = (state != IDLE);

  always_comb begin
    state_d     = state;
    target_d    = target;
    idx_d       = idx;
    is_fib_d    = is_fib;
    fib_index_d = fib_index;
    done_d      = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          target_d    = value;
          is_fib_d    = 1'b0;
          fib_index_d = '0;
          if (value == '0) begin
            is_fib_d = 1'b1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            load    = 1'b1;
            idx_d   = IDX_W'(1);
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (hit) begin
          is_fib_d    = 1'b1;
          fib_index_d = idx;
          done_d      = 1'b1;
          state_d     = DONE;
        end else if (over || at_max) begin
          is_fib_d    = 1'b0;
          fib_index_d = '0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          advance = 1'b1;
          idx_d   = idx + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      idx       <= '0;
      is_fib    <= 1'b0;
      fib_index <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      target    <= target_d;
      idx       <= idx_d;
      is_fib    <= is_fib_d;
      fib_index <= fib_index_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_fib_index_finder.sv
// Directed bench for fib_index_finder with a done-driven scoreboard.
// Expected results carry the cycle on which done must appear.
module tb_fib_index_finder;
  import fib_pkg::*;

  localparam int W  = 69;
  localparam int IW = 7;

  typedef struct {
    logic          f;
    logic [IW-1:0] i;
    int            c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  value = '0;
  logic          busy;
  logic          done;
  logic          is_fib;
  logic [IW-1:0] fib_index;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  exp_t sb[$];
  exp_t m_e;

  fib_index_finder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .is_fib   (is_fib),
    .fib_index(fib_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("is_fib", {127'd0, is_fib}, {127'd0, m_e.f});
        chk("fib_index", {121'd0, fib_index}, {121'd0, m_e.i});
        chk("done_cycle", cyc, m_e.c);
      end
    end
  end

  function automatic void model(input logic [W-1:0] v,
                                output logic f,
                                output logic [IW-1:0] n,
                                output int k);
    logic [W:0] a, b, t;
    f = 1'b0;
    n = '0;
    k = 100;
    if (v == '0) begin
      f = 1'b1;
      k = 0;
      return;
    end
    a = 1;
    b = 0;
    for (int i = 1; i <= 100; i++) begin
      if (a == {1'b0, v}) begin
        f = 1'b1;
        n = IW'(i);
        k = i;
        return;
      end
      if (a > {1'b0, v}) begin
        k = i;
        return;
      end
      if (i == 100) return;
      t = a + b;
      b = a;
      a = t;
    end
  endfunction

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++)
      @(negedge clk);
    chk("timeout", sb.size(), 0);
  endtask

  task automatic req(input logic [W-1:0] v,
                     input logic f,
                     input logic [IW-1:0] n,
                     input int k);
    @(negedge clk);
    for (int i = 0; i < 300 && busy; i++)
      @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    sb.push_back('{f, n, cyc + k});
    start = 1'b0;
    wait_empty(k + 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          mf;
    logic [IW-1:0] mn;
    int            mk;
    int            c0;
    logic [W-1:0]  probe [5];

    repeat (2) @(negedge clk);
    chk("rst_busy", {127'd0, busy}, 0);
    chk("rst_done", {127'd0, done}, 0);
    chk("rst_is_fib", {127'd0, is_fib}, 0);
    chk("rst_fib_index", {121'd0, fib_index}, 0);
    rst = 1'b0;

    // value 0 resolves on the accepting edge
    @(negedge clk);
    start = 1'b1;
    value = '0;
    @(posedge clk);
    #1;
    sb.push_back('{1'b1, 7'd0, cyc});
    start = 1'b0;
    chk("zero_busy_on", {127'd0, busy}, 1);
    chk("zero_done_on", {127'd0, done}, 1);
    @(posedge clk);
    #1;
    chk("zero_busy_off", {127'd0, busy}, 0);
    wait_empty(5);

    req(69'd55, 1'b1, 7'd10, 10);
    req(69'd1,  1'b1, 7'd1,  1);
    req(69'd4,  1'b0, 7'd0,  5);
    req(69'd2,  1'b1, 7'd3,  3);
    req(F_MAX,  1'b1, 7'd100, 100);
    req(F_MAX + 69'd1, 1'b0, 7'd0, 100);

    // abort mid-search with reset
    @(negedge clk);
    start = 1'b1;
    value = 69'd6765;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {127'd0, busy}, 0);
    chk("abort_done", {127'd0, done}, 0);
    chk("abort_is_fib", {127'd0, is_fib}, 0);
    chk("abort_fib_index", {121'd0, fib_index}, 0);
    @(negedge clk);
    rst = 1'b0;
    req(69'd6765, 1'b1, 7'd20, 20);

    probe[0] = 69'd3;
    probe[1] = 69'd144;
    probe[2] = 69'd145;
    probe[3] = 69'd1000;
    probe[4] = 69'd89;
    foreach (probe[j]) begin
      model(probe[j], mf, mn, mk);
      req(probe[j], mf, mn, mk);
    end

    // start held high; only IDLE-cycle values may be taken
    c0 = 0;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      start = 1'b1;
      value = (t % 8 == 0) ? 69'd8 : W'(99 + t);
      @(posedge clk);
      #1;
      if (t == 0) begin
        c0 = cyc;
        for (int r = 0; r < 3; r++)
          sb.push_back('{1'b1, 7'd6, c0 + 6 + 8 * r});
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_empty(20);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
